// File: rtl/apb3_value_bank_pkg.sv
// Shared constants and types for the APB3 value bank: register map, bit positions
// and the APB access state encoding.
package apb3_value_bank_pkg;

   localparam int unsigned OffCtrl   = 'h00;
   localparam int unsigned OffStatus = 'h04;
   localparam int unsigned OffCommit = 'h08;
   localparam int unsigned OffCount  = 'h0C;
   localparam int unsigned OffChBase = 'h10;

   localparam int unsigned CtrlAutoBit  = 0;
   localparam int unsigned CtrlClearBit = 1;

   localparam int unsigned StatBusyBit  = 0;
   localparam int unsigned StatPendBit  = 1;
   localparam int unsigned StatDirtyLsb = 8;

   localparam int unsigned CountW   = 16;
   localparam int unsigned WaitCntW = 2;

   // The setup phase is the StIdle cycle that sees PSEL high with PENABLE low.
   typedef enum logic {
      StIdle,
      StAccess
   } apb_state_e;

   function automatic int unsigned word_of(input int unsigned byte_off);
      return byte_off >> 2;
   endfunction

endpackage

// File: rtl/apb3_value_bank_if.sv
// APB3 completer-side bus bundle for the value bank.
interface apb3_value_bank_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERROR;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERROR
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERROR
   );
endinterface

// File: rtl/apb3_access_ctrl.sv
// APB3 access sequencer: tracks setup/access phases, inserts wait states and emits
// single-cycle write/read enables on the completing cycle.
module apb3_access_ctrl
   import apb3_value_bank_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic                  pwrite_i,
   input  logic [ADDR_WIDTH-1:0] paddr_i,
   output logic                  pready_o,
   output logic                  wr_en_o,
   output logic                  rd_en_o,
   output logic [ADDR_WIDTH-3:0] addr_o
);

   apb_state_e            state_q, state_d;
   logic [WaitCntW-1:0]   cnt_q, cnt_d;
   logic                  unused_addr_lsb;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pready_o = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (psel_i && !penable_i) begin
               state_d = StAccess;
               cnt_d   = WaitCntW'(WAIT_STATES);
            end
         end
         StAccess: begin
            // A deselect mid-access abandons the transfer without completing it.
            if (!psel_i) begin
               state_d = StIdle;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - WaitCntW'(1);
            end else begin
               pready_o = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wr_en_o         = psel_i & penable_i & pready_o & pwrite_i;
   assign rd_en_o         = psel_i & penable_i & pready_o & ~pwrite_i;
   assign addr_o          = paddr_i[ADDR_WIDTH-1:2];
   assign unused_addr_lsb = ^paddr_i[1:0];

endmodule

// File: rtl/apb3_value_bank.sv
// APB3 shadow value bank: CPU loads per-channel shadows, then commits them atomically
// to val_out with a strobe held until the consumer acknowledges.
module apb3_value_bank
   import apb3_value_bank_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned VAL_WIDTH   = 20,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                          clk,
   input  logic                          resetn,
   apb3_value_bank_if.slave              apb,
   output logic [NUM_CH*VAL_WIDTH-1:0]   val_out,
   output logic                          val_stb,
   input  logic                          val_ack,
   output logic                          busy
);

   localparam int unsigned WordW  = ADDR_WIDTH - 2;
   localparam int unsigned ChIdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef logic [NUM_CH-1:0][VAL_WIDTH-1:0] bank_t;

   logic             pready, wr_en, rd_en;
   logic [WordW-1:0] word, ch_off;
   logic [ChIdxW-1:0] ch_idx;
   logic             hit_ctrl, hit_status, hit_commit, hit_count, hit_ch, acc_err, wr_ok;
   logic [DATA_WIDTH-1:0] rdata;
   logic             unused_wdata;

   logic              auto_q, auto_d;
   bank_t             shadow_q, shadow_d;
   bank_t             val_out_q, val_out_d;
   logic [NUM_CH-1:0] dirty_q, dirty_d;
   logic              pending_q, pending_d;
   logic              busy_q, busy_d;
   logic              val_stb_q, val_stb_d;
   logic [CountW-1:0] count_q, count_d;

   apb3_access_ctrl #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WAIT_STATES (WAIT_STATES)
   ) u_access_ctrl (
      .clk       (clk),
      .resetn    (resetn),
      .psel_i    (apb.PSEL),
      .penable_i (apb.PENABLE),
      .pwrite_i  (apb.PWRITE),
      .paddr_i   (apb.PADDR),
      .pready_o  (pready),
      .wr_en_o   (wr_en),
      .rd_en_o   (rd_en),
      .addr_o    (word)
   );

   always_comb begin
      ch_off     = word - WordW'(word_of(OffChBase));
      ch_idx     = ch_off[ChIdxW-1:0];
      hit_ctrl   = (word == WordW'(word_of(OffCtrl)));
      hit_status = (word == WordW'(word_of(OffStatus)));
      hit_commit = (word == WordW'(word_of(OffCommit)));
      hit_count  = (word == WordW'(word_of(OffCount)));
      hit_ch     = (word >= WordW'(word_of(OffChBase))) && (ch_off < WordW'(NUM_CH));
      acc_err    = !(hit_ctrl || hit_status || hit_commit || hit_count || hit_ch)
                   || (apb.PWRITE && (hit_status || hit_count))
                   || (!apb.PWRITE && hit_commit);
      wr_ok      = wr_en && !acc_err;
   end

   always_comb begin
      rdata = '0;
      if (hit_ctrl) begin
         rdata[CtrlAutoBit] = auto_q;
      end else if (hit_status) begin
         rdata[StatBusyBit]              = busy_q;
         rdata[StatPendBit]              = pending_q;
         rdata[StatDirtyLsb +: NUM_CH]   = dirty_q;
      end else if (hit_count) begin
         rdata[CountW-1:0] = count_q;
      end else if (hit_ch) begin
         rdata[VAL_WIDTH-1:0] = shadow_q[ch_idx];
      end
   end

   // Every commit request funnels through pending; it fires on the first non-busy edge.
   always_comb begin
      auto_d    = auto_q;
      shadow_d  = shadow_q;
      dirty_d   = dirty_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      val_stb_d = val_stb_q;
      val_out_d = val_out_q;
      count_d   = count_q;

      if (val_stb_q && val_ack) begin
         val_stb_d = 1'b0;
         busy_d    = 1'b0;
      end

      if (pending_q && !busy_q) begin
         val_out_d = shadow_q;
         dirty_d   = '0;
         count_d   = count_q + CountW'(1);
         val_stb_d = 1'b1;
         busy_d    = 1'b1;
         pending_d = 1'b0;
      end

      if (wr_ok) begin
         if (hit_ctrl) begin
            auto_d = apb.PWDATA[CtrlAutoBit];
            if (apb.PWDATA[CtrlClearBit]) begin
               shadow_d  = '0;
               dirty_d   = '0;
               pending_d = 1'b0;
            end
         end
         if (hit_commit) begin
            pending_d = 1'b1;
         end
         if (hit_ch) begin
            shadow_d[ch_idx] = apb.PWDATA[VAL_WIDTH-1:0];
            dirty_d[ch_idx]  = 1'b1;
            if (auto_q) begin
               pending_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         auto_q    <= 1'b0;
         shadow_q  <= '0;
         dirty_q   <= '0;
         pending_q <= 1'b0;
         busy_q    <= 1'b0;
         val_stb_q <= 1'b0;
         val_out_q <= '0;
         count_q   <= '0;
      end else begin
         auto_q    <= auto_d;
         shadow_q  <= shadow_d;
         dirty_q   <= dirty_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
         val_stb_q <= val_stb_d;
         val_out_q <= val_out_d;
         count_q   <= count_d;
      end
   end

   assign apb.PREADY    = pready;
   assign apb.PSLVERROR = pready & acc_err;
   assign apb.PRDATA    = (rd_en && !acc_err) ? rdata : '0;
   assign val_out       = val_out_q;
   assign val_stb       = val_stb_q;
   assign busy          = busy_q;
   assign unused_wdata  = ^apb.PWDATA;

endmodule

// File: tb/tb_apb3_value_bank.sv
// Directed bench for apb3_value_bank: a zero-wait instance for the register map and
// commit handshake, plus a two-wait-state instance for auto-commit and aborted access.
module tb_apb3_value_bank;

   localparam int unsigned NCH = 4;
   localparam int unsigned VW  = 20;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic val_ack;
   logic [NCH*VW-1:0] val_out0, val_out1;
   logic stb0, stb1, busy0, busy1;

   int total = 0;
   int bad   = 0;

   apb3_value_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
   apb3_value_bank_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus1 ();

   apb3_value_bank #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_CH(NCH), .VAL_WIDTH(VW), .WAIT_STATES(0)
   ) u_dut0 (
      .clk(clk), .resetn(resetn), .apb(bus0), .val_out(val_out0), .val_stb(stb0),
      .val_ack(val_ack), .busy(busy0)
   );

   apb3_value_bank #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_CH(NCH), .VAL_WIDTH(VW), .WAIT_STATES(2)
   ) u_dut1 (
      .clk(clk), .resetn(resetn), .apb(bus1), .val_out(val_out1), .val_stb(stb1),
      .val_ack(val_ack), .busy(busy1)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs [26];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      bus0.PSEL = 1'b0; bus0.PENABLE = 1'b0; bus0.PWRITE = 1'b0;
      bus0.PADDR = '0;  bus0.PWDATA = '0;
      bus1.PSEL = 1'b0; bus1.PENABLE = 1'b0; bus1.PWRITE = 1'b0;
      bus1.PADDR = '0;  bus1.PWDATA = '0;
   endtask

   // Returns one posedge (+1) after the completing edge.
   task automatic apb(input int d, input logic wr, input logic [15:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int waits);
      @(negedge clk);
      bus0.PADDR = addr; bus0.PWRITE = wr; bus0.PWDATA = wdata;
      bus1.PADDR = addr; bus1.PWRITE = wr; bus1.PWDATA = wdata;
      bus0.PSEL = (d == 0); bus1.PSEL = (d == 1);
      bus0.PENABLE = 1'b0; bus1.PENABLE = 1'b0;
      @(negedge clk);
      bus0.PENABLE = (d == 0); bus1.PENABLE = (d == 1);
      #1;
      waits = 0;
      while (!(d == 0 ? bus0.PREADY : bus1.PREADY) && waits < 8) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (waits >= 8) begin
         total++;
         bad++;
         $display("FAIL pready_timeout: got no PREADY want PREADY");
      end
      rdata = (d == 0) ? bus0.PRDATA : bus1.PRDATA;
      err   = (d == 0) ? bus0.PSLVERROR : bus1.PSLVERROR;
      @(posedge clk);
      #1;
      bus_idle();
   endtask

   task automatic wr(input int d, input logic [15:0] a, input logic [31:0] v);
      logic [31:0] r;
      logic e;
      int w;
      apb(d, 1'b1, a, v, r, e, w);
   endtask

   task automatic rd_chk(input int d, input logic [15:0] a, input logic [31:0] exp,
                         input string name);
      logic [31:0] r;
      logic e;
      int w;
      apb(d, 1'b0, a, 32'h0, r, e, w);
      check(name, r, exp);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      logic e;
      int w;
      int rises;
      logic prev;

      vecs[0]  = '{1'b0, 16'h000C, 32'h0,        32'h0,        1'b0};
      vecs[1]  = '{1'b0, 16'h0004, 32'h0,        32'h0,        1'b0};
      vecs[2]  = '{1'b0, 16'h0010, 32'h0,        32'h0,        1'b0};
      vecs[3]  = '{1'b0, 16'h0000, 32'h0,        32'h0,        1'b0};
      vecs[4]  = '{1'b1, 16'h0018, 32'hFFF12345, 32'h0,        1'b0};
      vecs[5]  = '{1'b0, 16'h0018, 32'h0,        32'h00012345, 1'b0};
      vecs[6]  = '{1'b0, 16'h0004, 32'h0,        32'h00000400, 1'b0};
      vecs[7]  = '{1'b1, 16'h0004, 32'h1,        32'h0,        1'b1};
      vecs[8]  = '{1'b1, 16'h000C, 32'h5,        32'h0,        1'b1};
      vecs[9]  = '{1'b0, 16'h0008, 32'h0,        32'h0,        1'b1};
      vecs[10] = '{1'b0, 16'h0040, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{1'b1, 16'h0040, 32'hDEAD,     32'h0,        1'b1};
      vecs[12] = '{1'b0, 16'h1000, 32'h0,        32'h0,        1'b1};
      vecs[13] = '{1'b0, 16'h000C, 32'h0,        32'h0,        1'b0};
      vecs[14] = '{1'b0, 16'h0004, 32'h0,        32'h00000400, 1'b0};
      vecs[15] = '{1'b1, 16'h0017, 32'h000ABCDE, 32'h0,        1'b0};
      vecs[16] = '{1'b0, 16'h0014, 32'h0,        32'h000ABCDE, 1'b0};
      vecs[17] = '{1'b0, 16'h0004, 32'h0,        32'h00000600, 1'b0};
      vecs[18] = '{1'b1, 16'h0000, 32'h2,        32'h0,        1'b0};
      vecs[19] = '{1'b0, 16'h0004, 32'h0,        32'h0,        1'b0};
      vecs[20] = '{1'b0, 16'h0018, 32'h0,        32'h0,        1'b0};
      vecs[21] = '{1'b0, 16'h0014, 32'h0,        32'h0,        1'b0};
      vecs[22] = '{1'b1, 16'h0000, 32'h1,        32'h0,        1'b0};
      vecs[23] = '{1'b0, 16'h0000, 32'h0,        32'h1,        1'b0};
      vecs[24] = '{1'b1, 16'h0000, 32'h0,        32'h0,        1'b0};
      vecs[25] = '{1'b0, 16'h0000, 32'h0,        32'h0,        1'b0};

      bus_idle();
      val_ack = 1'b1;
      resetn  = 1'b0;
      #12;
      check("reset stb", {31'b0, stb0}, 32'h0);
      check("reset busy", {31'b0, busy0}, 32'h0);
      check("reset val_out", {31'b0, |val_out0}, 32'h0);
      check("reset pready", {31'b0, bus0.PREADY}, 32'h0);
      check("reset prdata", bus0.PRDATA, 32'h0);
      check("reset pslverr", {31'b0, bus0.PSLVERROR}, 32'h0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Register map, error responses and soft clear
      for (int i = 0; i < 26; i++) begin
         apb(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e, w);
         check($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, vecs[i].err});
         check($sformatf("vec%0d waits", i), 32'(w), 32'd0);
         if (!vecs[i].wr || vecs[i].err) begin
            check($sformatf("vec%0d rdata", i), r, vecs[i].rdata);
         end
      end
      check("no stray strobe", {31'b0, stb0}, 32'h0);

      // Basic commit with ack tied high
      wr(0, 16'h0010, 32'h00062);
      wr(0, 16'h0014, 32'h0004B);
      wr(0, 16'h0008, 32'h0);
      check("commit stb before", {31'b0, stb0}, 32'h0);
      @(posedge clk); #1;
      check("commit ch0", 32'(val_out0[19:0]), 32'h62);
      check("commit ch1", 32'(val_out0[39:20]), 32'h4B);
      check("commit stb", {31'b0, stb0}, 32'h1);
      check("commit busy", {31'b0, busy0}, 32'h1);
      @(posedge clk); #1;
      check("commit stb drop", {31'b0, stb0}, 32'h0);
      check("commit busy drop", {31'b0, busy0}, 32'h0);
      rd_chk(0, 16'h000C, 32'h1, "count after commit");
      rd_chk(0, 16'h0004, 32'h0, "status after commit");

      // Stalled consumer: three requests collapse into one pending commit
      val_ack = 1'b0;
      repeat (3) wr(0, 16'h0008, 32'h0);
      rd_chk(0, 16'h0004, 32'h3, "status stalled");
      check("stalled stb", {31'b0, stb0}, 32'h1);
      rd_chk(0, 16'h000C, 32'h2, "count stalled");
      @(negedge clk);
      val_ack = 1'b1;
      @(posedge clk); #1;
      check("ack stb drop", {31'b0, stb0}, 32'h0);
      check("ack busy drop", {31'b0, busy0}, 32'h0);
      @(posedge clk); #1;
      check("pending stb", {31'b0, stb0}, 32'h1);
      check("pending busy", {31'b0, busy0}, 32'h1);
      rises = 0;
      prev  = stb0;
      repeat (8) begin
         @(posedge clk); #1;
         if (stb0 && !prev) rises++;
         prev = stb0;
      end
      check("no extra strobe", 32'(rises), 32'd0);
      rd_chk(0, 16'h000C, 32'h3, "count after pending");
      rd_chk(0, 16'h0004, 32'h0, "status after pending");

      // Two wait states with auto-commit
      apb(1, 1'b1, 16'h0000, 32'h1, r, e, w);
      check("ws2 ctrl waits", 32'(w), 32'd2);
      apb(1, 1'b1, 16'h001C, 32'hFFFFF, r, e, w);
      check("ws2 ch3 waits", 32'(w), 32'd2);
      check("ws2 ch3 err", {31'b0, e}, 32'h0);
      @(posedge clk); #1;
      check("auto ch3", 32'(val_out1[79:60]), 32'hFFFFF);
      check("auto stb", {31'b0, stb1}, 32'h1);
      @(posedge clk); #1;
      check("auto stb drop", {31'b0, stb1}, 32'h0);
      rd_chk(1, 16'h000C, 32'h1, "auto count");

      // PSEL dropped before PREADY: the write must not land
      @(negedge clk);
      bus1.PADDR = 16'h0010; bus1.PWRITE = 1'b1; bus1.PWDATA = 32'h123; bus1.PSEL = 1'b1;
      @(negedge clk);
      bus1.PENABLE = 1'b1;
      #1;
      check("abort pready", {31'b0, bus1.PREADY}, 32'h0);
      @(negedge clk);
      bus_idle();
      repeat (2) @(negedge clk);
      rd_chk(1, 16'h0010, 32'h0, "abort ch0");
      rd_chk(1, 16'h0004, 32'h0, "abort status");
      rd_chk(1, 16'h000C, 32'h1, "abort count");

      // COUNT wrap: preload rather than issuing 65k commits
      force u_dut0.count_q = 16'hFFFE;
      @(posedge clk); #1;
      release u_dut0.count_q;
      wr(0, 16'h0008, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rd_chk(0, 16'h000C, 32'hFFFF, "count ffff");
      wr(0, 16'h0008, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rd_chk(0, 16'h000C, 32'h0, "count wrap");

      // Asynchronous reset in the middle of a handshake
      val_ack = 1'b0;
      wr(0, 16'h0008, 32'h0);
      @(posedge clk); #1;
      check("pre-reset stb", {31'b0, stb0}, 32'h1);
      #2;
      resetn = 1'b0;
      #1;
      check("async rst stb", {31'b0, stb0}, 32'h0);
      check("async rst busy", {31'b0, busy0}, 32'h0);
      check("async rst val_out", {31'b0, |val_out0}, 32'h0);
      repeat (2) @(negedge clk);
      resetn  = 1'b1;
      val_ack = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post-reset stb", {31'b0, stb0}, 32'h0);
      rd_chk(0, 16'h000C, 32'h0, "post-reset count");
      rd_chk(0, 16'h0010, 32'h0, "post-reset ch0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
